// File: rtl/color_pkg.sv
// Shared colour-path definitions: field widths, hue/divisor constants and stage payload types.
// Used by both the HSV-to-RGB and RGB-to-HSV converters.
package color_pkg;

    localparam int unsigned HUE_W      = 9;
    localparam int unsigned CH_W       = 8;
    localparam int unsigned HUE_MAX    = 360;
    localparam int unsigned SECTOR_DEG = 60;
    localparam int unsigned DIV_Q      = 15300;
    localparam int unsigned DIV_P      = 255;

    localparam int unsigned FRAC_W = 6;        // f in 0..59
    localparam int unsigned SF_W   = 14;       // s*f and 15300 both fit
    localparam int unsigned PN_W   = 2 * CH_W;
    localparam int unsigned QN_W   = 22;

    typedef enum logic [2:0] {
        SecRed     = 3'd0,
        SecYellow  = 3'd1,
        SecGreen   = 3'd2,
        SecCyan    = 3'd3,
        SecBlue    = 3'd4,
        SecMagenta = 3'd5
    } sector_t;

    typedef struct packed {
        sector_t            sector;
        logic [FRAC_W-1:0]  frac;
        logic [CH_W-1:0]    sat;
        logic [CH_W-1:0]    val;
    } hsv_norm_t;

    typedef struct packed {
        sector_t            sector;
        logic [CH_W-1:0]    val;
        logic [PN_W-1:0]    pn;
        logic [QN_W-1:0]    qn;
        logic [QN_W-1:0]    tn;
    } hsv_prod_t;

    // A single subtraction is enough: the 9-bit range tops out below 2*360.
    function automatic logic [HUE_W-1:0] wrap_hue(input logic [HUE_W-1:0] hue);
        return (hue >= HUE_W'(HUE_MAX)) ? hue - HUE_W'(HUE_MAX) : hue;
    endfunction

endpackage

// File: rtl/const_div.sv
// Exact truncating unsigned division by a constant: reciprocal estimate plus one
// remainder correction.
module const_div #(
    parameter int unsigned Divisor  = 255,
    parameter int unsigned InWidth  = 16,
    parameter int unsigned OutWidth = 8
) (
    input  logic [InWidth-1:0]  dividend,
    output logic [OutWidth-1:0] quotient
);

    localparam int unsigned     ProdW = 2 * InWidth;
    localparam longint unsigned Recip = (64'd1 << InWidth) / 64'(Divisor);

    // With Recip = floor(2^InWidth / D) and dividend < 2^InWidth the estimate is
    // either exact or one low, so a single remainder check makes it exact.
    logic [ProdW-1:0]   prod;
    logic [InWidth-1:0] q_est;
    logic [InWidth-1:0] rem;
    logic [InWidth-1:0] q_fix;

    always_comb begin
        prod  = ProdW'(dividend) * ProdW'(Recip);
        q_est = InWidth'(prod >> InWidth);
        rem   = dividend - q_est * InWidth'(Divisor);
        q_fix = (rem >= InWidth'(Divisor)) ? q_est + InWidth'(1) : q_est;
    end

    assign quotient = OutWidth'(q_fix);

endmodule

// File: rtl/hsv2rgb.sv
// Streaming HSV-to-RGB converter: hue normalise, products, divide/select; 3 register
// stages with a whole-pipeline stall on output backpressure.
module hsv2rgb
    import color_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [HUE_W-1:0] hue,
    input  logic [CH_W-1:0]  saturation,
    input  logic [CH_W-1:0]  value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  red,
    output logic [CH_W-1:0]  green,
    output logic [CH_W-1:0]  blue
);

    logic stall;
    logic s1_valid_q;
    logic s2_valid_q;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Stage 1: hue normalisation
    logic [HUE_W-1:0] hue_norm;
    logic [2:0]       sector_raw;
    hsv_norm_t        s1_d;
    hsv_norm_t        s1_q;

    always_comb begin
        hue_norm    = wrap_hue(hue);
        sector_raw  = 3'(hue_norm / HUE_W'(SECTOR_DEG));
        s1_d.sector = sector_t'(sector_raw);
        s1_d.frac   = FRAC_W'(hue_norm - HUE_W'(SECTOR_DEG) * HUE_W'(sector_raw));
        s1_d.sat    = saturation;
        s1_d.val    = value;
    end

    // Stage 2: full-width products
    logic [CH_W-1:0] sat_inv;
    logic [SF_W-1:0] sat_f;
    logic [SF_W-1:0] sat_g;
    hsv_prod_t       s2_d;
    hsv_prod_t       s2_q;

    always_comb begin
        sat_inv     = CH_W'(DIV_P) - s1_q.sat;
        sat_f       = SF_W'(s1_q.sat) * SF_W'(s1_q.frac);
        sat_g       = SF_W'(s1_q.sat) * SF_W'(FRAC_W'(SECTOR_DEG) - s1_q.frac);
        s2_d.sector = s1_q.sector;
        s2_d.val    = s1_q.val;
        s2_d.pn     = PN_W'(s1_q.val) * PN_W'(sat_inv);
        s2_d.qn     = QN_W'(s1_q.val) * QN_W'(SF_W'(DIV_Q) - sat_f);
        s2_d.tn     = QN_W'(s1_q.val) * QN_W'(SF_W'(DIV_Q) - sat_g);
    end

    // Stage 3: exact divides and sector select
    logic [CH_W-1:0] p_val;
    logic [CH_W-1:0] q_val;
    logic [CH_W-1:0] t_val;
    logic [CH_W-1:0] red_d;
    logic [CH_W-1:0] green_d;
    logic [CH_W-1:0] blue_d;

    const_div #(
        .Divisor  (DIV_P),
        .InWidth  (PN_W),
        .OutWidth (CH_W)
    ) u_div_p (
        .dividend (s2_q.pn),
        .quotient (p_val)
    );

    const_div #(
        .Divisor  (DIV_Q),
        .InWidth  (QN_W),
        .OutWidth (CH_W)
    ) u_div_q (
        .dividend (s2_q.qn),
        .quotient (q_val)
    );

    const_div #(
        .Divisor  (DIV_Q),
        .InWidth  (QN_W),
        .OutWidth (CH_W)
    ) u_div_t (
        .dividend (s2_q.tn),
        .quotient (t_val)
    );

    always_comb begin
        red_d   = s2_q.val;
        green_d = t_val;
        blue_d  = p_val;
        unique case (s2_q.sector)
            SecRed:     begin red_d = s2_q.val; green_d = t_val;     blue_d = p_val;     end
            SecYellow:  begin red_d = q_val;     green_d = s2_q.val; blue_d = p_val;     end
            SecGreen:   begin red_d = p_val;     green_d = s2_q.val; blue_d = t_val;     end
            SecCyan:    begin red_d = p_val;     green_d = q_val;     blue_d = s2_q.val; end
            SecBlue:    begin red_d = t_val;     green_d = p_val;     blue_d = s2_q.val; end
            SecMagenta: begin red_d = s2_q.val; green_d = p_val;     blue_d = q_val;     end
            default:    begin red_d = s2_q.val; green_d = t_val;     blue_d = p_val;     end
        endcase
    end

    // Control and outputs: reset wins over stall
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            out_valid  <= 1'b0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
        end else if (!stall) begin
            s1_valid_q <= in_valid;
            s2_valid_q <= s1_valid_q;
            out_valid  <= s2_valid_q;
            if (s2_valid_q) begin
                red   <= red_d;
                green <= green_d;
                blue  <= blue_d;
            end
        end
    end

    // Datapath registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

endmodule
